// File: rtl/sprite_scroller.sv
// sprite_scroller: per-frame motion engine for NUM_OBJ background sprites.
// Each channel keeps an unsigned fixed-point X, an integer Y, a signed
// sub-pixel velocity and a wrap/ping-pong mode. A single-cycle config port
// reloads one channel; a write beats that channel's motion on the same edge.
module sprite_scroller #(
    parameter int NUM_OBJ   = 4,
    parameter int POS_W     = 10,
    parameter int FRAC_W    = 4,
    parameter int SPD_W     = 8,
    parameter int X_SPAN    = 700,
    parameter int X_INIT    = 20,
    parameter int X_SPACING = 200,
    parameter int Y_INIT    = 20,
    parameter int DEF_SPEED = 16,
    parameter int OBJ_W     = 80,
    parameter int OBJ_H     = 40
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic                       run,
    input  logic                       cfg_we,
    input  logic [2:0]                 cfg_idx,
    input  logic [POS_W-1:0]           cfg_x,
    input  logic [POS_W-1:0]           cfg_y,
    input  logic [SPD_W-1:0]           cfg_speed,
    input  logic                       cfg_mode,
    output logic [NUM_OBJ*POS_W-1:0]   obj_x,
    output logic [NUM_OBJ*POS_W-1:0]   obj_y,
    output logic [NUM_OBJ-1:0]         obj_wrap,
    output logic [POS_W-1:0]           obj_w,
    output logic [POS_W-1:0]           obj_h
);

    localparam int XW = POS_W + FRAC_W;
    // Two guard bits: one for overflow past the span, one for sign.
    localparam int NW = XW + 2;

    localparam logic signed [NW-1:0]    S_FX   = NW'(X_SPAN * (2 ** FRAC_W));
    localparam logic signed [NW-1:0]    ONE_PX = NW'(2 ** FRAC_W);
    localparam logic [XW-1:0]           TOP_FX = XW'((X_SPAN - 1) * (2 ** FRAC_W));
    localparam logic signed [SPD_W-1:0] V_MIN  = {1'b1, {(SPD_W-1){1'b0}}};
    localparam logic signed [SPD_W-1:0] V_MAX  = {1'b0, {(SPD_W-1){1'b1}}};

    logic [XW-1:0]           x_q    [NUM_OBJ];
    logic [XW-1:0]           x_d    [NUM_OBJ];
    logic [POS_W-1:0]        y_q    [NUM_OBJ];
    logic [POS_W-1:0]        y_d    [NUM_OBJ];
    logic signed [SPD_W-1:0] v_q    [NUM_OBJ];
    logic signed [SPD_W-1:0] v_d    [NUM_OBJ];
    logic [NUM_OBJ-1:0]      mode_q;
    logic [NUM_OBJ-1:0]      mode_d;
    logic [NUM_OBJ-1:0]      wrap_q;
    logic [NUM_OBJ-1:0]      wrap_d;

    function automatic logic [XW-1:0] rst_x(input int idx);
        int            p;
        logic [XW-1:0] r;
        p = (X_INIT + idx * X_SPACING) % X_SPAN;
        r = XW'(p);
        return r << FRAC_W;
    endfunction

    // Bounce reversal; the most-negative velocity has no positive twin, so clamp.
    function automatic logic signed [SPD_W-1:0] neg_sat(input logic signed [SPD_W-1:0] v);
        return (v == V_MIN) ? V_MAX : -v;
    endfunction

    // Channel state registers with asynchronous reset to the staggered start layout.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                x_q[i] <= rst_x(i);
                y_q[i] <= POS_W'(Y_INIT);
                v_q[i] <= SPD_W'(DEF_SPEED);
            end
            mode_q <= '0;
            wrap_q <= '0;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
                v_q[i] <= v_d[i];
            end
            mode_q <= mode_d;
            wrap_q <= wrap_d;
        end
    end

    // Per-channel motion step followed by config override of the addressed channel.
    always_comb begin : next_state_c
        logic signed [NW-1:0] n;
        logic signed [NW-1:0] n_adj;
        n      = '0;
        n_adj  = '0;
        mode_d = mode_q;
        wrap_d = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            v_d[i] = v_q[i];
            n      = $signed({2'b00, x_q[i]}) + NW'(v_q[i]);
            n_adj  = n;
            if (run && (v_q[i] != '0)) begin
                if (!mode_q[i]) begin
                    if (n >= S_FX) begin
                        n_adj     = n - S_FX;
                        wrap_d[i] = 1'b1;
                    end else if (n[NW-1]) begin
                        n_adj     = n + S_FX;
                        wrap_d[i] = 1'b1;
                    end
                    x_d[i] = n_adj[XW-1:0];
                end else begin
                    if (n > (S_FX - ONE_PX)) begin
                        x_d[i]    = TOP_FX;
                        v_d[i]    = neg_sat(v_q[i]);
                        wrap_d[i] = 1'b1;
                    end else if (n[NW-1]) begin
                        x_d[i]    = '0;
                        v_d[i]    = neg_sat(v_q[i]);
                        wrap_d[i] = 1'b1;
                    end else begin
                        x_d[i] = n[XW-1:0];
                    end
                end
            end
            // Indices at or above NUM_OBJ never match a channel, so they fall away here.
            if (cfg_we && (int'(cfg_idx) == i)) begin
                x_d[i]    = {cfg_x, {FRAC_W{1'b0}}};
                y_d[i]    = cfg_y;
                v_d[i]    = $signed(cfg_speed);
                mode_d[i] = cfg_mode;
                wrap_d[i] = 1'b0;
            end
        end
    end

    // Integer pixel outputs packed per channel.
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_pack
        assign obj_x[g*POS_W +: POS_W] = x_q[g][XW-1:FRAC_W];
        assign obj_y[g*POS_W +: POS_W] = y_q[g];
    end

    assign obj_wrap = wrap_q;
    assign obj_w    = POS_W'(OBJ_W);
    assign obj_h    = POS_W'(OBJ_H);

endmodule

// File: tb/tb_sprite_scroller.sv
// Bench for sprite_scroller: hand-computed vector table plus scripted
// sequences, with expectations queued per edge and compared after the edge.
module tb_sprite_scroller;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        run;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [9:0]  cfg_x;
    logic [9:0]  cfg_y;
    logic [7:0]  cfg_speed;
    logic        cfg_mode;
    logic [39:0] obj_x;
    logic [39:0] obj_y;
    logic [3:0]  obj_wrap;
    logic [9:0]  obj_w;
    logic [9:0]  obj_h;

    sprite_scroller dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .run       (run),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .cfg_speed (cfg_speed),
        .cfg_mode  (cfg_mode),
        .obj_x     (obj_x),
        .obj_y     (obj_y),
        .obj_wrap  (obj_wrap),
        .obj_w     (obj_w),
        .obj_h     (obj_h)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        bit       run;
        bit       we;
        bit [2:0] idx;
        int       x;
        int       y;
        int       sp;
        bit       mode;
        int       ch;
        int       ex;
        int       ey;
        bit       ew;
    } vec_t;

    typedef struct {
        int edge_no;
        int ch;
        int x;
        int y;
        bit wrap;
    } exp_t;

    vec_t vt[27];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;

    task automatic check_ch(input int ch, input int ex, input int ey, input bit ew);
        int ax;
        int ay;
        ax = int'(obj_x[ch*10 +: 10]);
        ay = int'(obj_y[ch*10 +: 10]);
        n_vec++;
        if (ax != ex) begin
            n_bad++;
            $display("FAIL edge%0d ch%0d obj_x: got %0d want %0d", edge_cnt, ch, ax, ex);
        end
        n_vec++;
        if (ay != ey) begin
            n_bad++;
            $display("FAIL edge%0d ch%0d obj_y: got %0d want %0d", edge_cnt, ch, ay, ey);
        end
        n_vec++;
        if (obj_wrap[ch] != ew) begin
            n_bad++;
            $display("FAIL edge%0d ch%0d obj_wrap: got %0b want %0b", edge_cnt, ch, obj_wrap[ch], ew);
        end
    endtask

    task automatic expect_next(input int ch, input int x, input int y, input bit w);
        exp_t e;
        e.edge_no = edge_cnt + 1;
        e.ch      = ch;
        e.x       = x;
        e.y       = y;
        e.wrap    = w;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            e = sb.pop_front();
            if (e.edge_no < edge_cnt) begin
                n_vec++;
                n_bad++;
                $display("FAIL stale expectation for edge%0d at edge%0d", e.edge_no, edge_cnt);
            end else begin
                check_ch(e.ch, e.x, e.y, e.wrap);
            end
        end
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, compare, return at next falling edge.
    task automatic apply(input bit r, input bit we, input bit [2:0] idx, input int x,
                         input int y, input int sp, input bit m);
        run       = r;
        cfg_we    = we;
        cfg_idx   = idx;
        cfg_x     = x[9:0];
        cfg_y     = y[9:0];
        cfg_speed = sp[7:0];
        cfg_mode  = m;
        @(posedge frame_clk);
        edge_cnt++;
        #1;
        drain();
        @(negedge frame_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //        run we idx  x    y   sp   md  ch  ex   ey  ew
        vt[0]  = '{1, 1, 1, 100,  50,   8,  0,  1, 100,  50, 0};
        vt[1]  = '{1, 0, 0,   0,   0,   0,  0,  1, 100,  50, 0};
        vt[2]  = '{1, 0, 0,   0,   0,   0,  0,  1, 101,  50, 0};
        vt[3]  = '{1, 0, 0,   0,   0,   0,  0,  1, 101,  50, 0};
        vt[4]  = '{1, 0, 0,   0,   0,   0,  0,  1, 102,  50, 0};
        vt[5]  = '{1, 1, 0,   1,  20, -32,  0,  0,   1,  20, 0};
        vt[6]  = '{1, 0, 0,   0,   0,   0,  0,  0, 699,  20, 1};
        vt[7]  = '{1, 0, 0,   0,   0,   0,  0,  0, 697,  20, 0};
        vt[8]  = '{1, 1, 2, 697,  30,  48,  1,  2, 697,  30, 0};
        vt[9]  = '{1, 0, 0,   0,   0,   0,  0,  2, 699,  30, 1};
        vt[10] = '{1, 0, 0,   0,   0,   0,  0,  2, 696,  30, 0};
        vt[11] = '{1, 1, 2,   2,  30, -48,  1,  2,   2,  30, 0};
        vt[12] = '{1, 0, 0,   0,   0,   0,  0,  2,   0,  30, 1};
        vt[13] = '{1, 0, 0,   0,   0,   0,  0,  2,   3,  30, 0};
        vt[14] = '{0, 0, 0,   0,   0,   0,  0,  3,  15,  20, 0};
        vt[15] = '{0, 0, 0,   0,   0,   0,  0,  0, 685,  20, 0};
        vt[16] = '{0, 1, 3, 400, 100,  16,  0,  3, 400, 100, 0};
        vt[17] = '{0, 1, 5,   0,   0,   0,  0,  1, 106,  50, 0};
        vt[18] = '{0, 0, 0,   0,   0,   0,  0,  2,   3,  30, 0};
        vt[19] = '{1, 0, 0,   0,   0,   0,  0,  3, 401, 100, 0};
        vt[20] = '{1, 1, 0,  10,   5,   0,  0,  0,  10,   5, 0};
        vt[21] = '{1, 0, 0,   0,   0,   0,  0,  0,  10,   5, 0};
        vt[22] = '{1, 1, 1, 720,  50,  16,  0,  1, 720,  50, 0};
        vt[23] = '{1, 0, 0,   0,   0,   0,  0,  1,  21,  50, 1};
        vt[24] = '{1, 1, 1,   5,  50, -128, 1,  1,   5,  50, 0};
        vt[25] = '{1, 0, 0,   0,   0,   0,  0,  1,   0,  50, 1};
        vt[26] = '{1, 0, 0,   0,   0,   0,  0,  1,   7,  50, 0};

        Reset     = 1'b1;
        run       = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_x     = '0;
        cfg_y     = '0;
        cfg_speed = '0;
        cfg_mode  = 1'b0;

        #3;
        for (int c = 0; c < 4; c++) check_ch(c, 20 + 200 * c, 20, 1'b0);
        n_vec++;
        if (obj_w != 10'd80 || obj_h != 10'd40) begin
            n_bad++;
            $display("FAIL obj_w/obj_h: got %0d/%0d want 80/40", obj_w, obj_h);
        end

        @(negedge frame_clk);
        Reset = 1'b0;

        // Free-running defaults: all channels +1 px/frame, ch3 wraps on edge 80.
        for (int k = 1; k <= 81; k++) begin
            if (k == 1) begin
                for (int c = 0; c < 4; c++) expect_next(c, 21 + 200 * c, 20, 1'b0);
            end
            if (k >= 79) begin
                expect_next(3, (620 + k) % 700, 20, k == 80);
                expect_next(0, 20 + k, 20, 1'b0);
            end
            apply(1'b1, 1'b0, 3'd0, 0, 0, 0, 1'b0);
        end

        for (int i = 0; i < 27; i++) begin
            expect_next(vt[i].ch, vt[i].ex, vt[i].ey, vt[i].ew);
            apply(vt[i].run, vt[i].we, vt[i].idx, vt[i].x, vt[i].y, vt[i].sp, vt[i].mode);
            if (!vt[i].run) begin
                n_vec++;
                if (obj_wrap != 4'b0000) begin
                    n_bad++;
                    $display("FAIL paused obj_wrap: got %b want 0000", obj_wrap);
                end
            end
        end

        // Asynchronous reset between edges.
        apply(1'b1, 1'b0, 3'd0, 0, 0, 0, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) check_ch(c, 20 + 200 * c, 20, 1'b0);
        @(negedge frame_clk);
        Reset = 1'b0;
        expect_next(0, 21, 20, 1'b0);
        expect_next(3, 621, 20, 1'b0);
        apply(1'b1, 1'b0, 3'd0, 0, 0, 0, 1'b0);

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
